// File: rtl/serial_sub_2.sv
// Multi-cycle two's-complement subtractor: A - B two bits per clock, LSB slice first,
// using A + ~B + 1 with a start/ready/busy/done handshake.
module serial_sub_2 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bn;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_carryOut;
  logic             r_overflow;

  logic             w_accept;
  logic             w_lastSlice;
  logic [CW:0]      w_bitLo;
  logic [CW:0]      w_bitHi;
  logic             w_s0;
  logic             w_s1;
  logic             w_cMid;
  logic             w_cOut;

  // Starts are only honoured while ready, i.e. outside RUN.
  assign w_accept    = start && (r_state != RUN);
  assign w_lastSlice = (r_count == CW'(SLICES - 1));
  assign w_bitLo     = {r_count, 1'b0};
  assign w_bitHi     = {r_count, 1'b1};

  assign {w_cMid, w_s0} = {1'b0, r_a[w_bitLo]} + {1'b0, r_bn[w_bitLo]} + {1'b0, r_carry};
  assign {w_cOut, w_s1} = {1'b0, r_a[w_bitHi]} + {1'b0, r_bn[w_bitHi]} + {1'b0, w_cMid};

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_lastSlice) w_nextState = DONE;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state != RUN);
    busy  = (r_state == RUN);
    done  = (r_state == DONE);
  end

  // Datapath: capture on accept, then one 2-bit slice per RUN cycle; flags latch on the last slice.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a        <= '0;
      r_bn       <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a      <= data_operandA;
      r_bn     <= ~data_operandB;
      r_carry  <= 1'b1;
      r_count  <= '0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_result[w_bitLo +: 2] <= {w_s1, w_s0};
      r_carry                <= w_cOut;
      if (w_lastSlice) begin
        r_carryOut <= w_cOut;
        r_overflow <= w_cMid ^ w_cOut;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_sub_2.sv
// Scoreboard bench for serial_sub_2: stimulus pushes model results, a negedge monitor
// pops and compares them whenever done pulses.
module tb_serial_sub_2;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_operandA = '0;
  logic [WIDTH-1:0] data_operandB = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             co;
    logic             ov;
    int               doneEdge;
  } expect_t;

  expect_t sbQueue[$];
  int      edgeCount = 0;
  int      checks    = 0;
  int      failures  = 0;

  serial_sub_2 #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ready(ready), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount = edgeCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // Reference model from the arithmetic definition of A - B.
  function automatic expect_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int doneEdge);
    expect_t e;
    e.diff     = a - b;
    e.co       = (a >= b);
    e.ov       = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    e.doneEdge = doneEdge;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) checkOutput("ready_busy_exclusive", {63'd0, ready ^ busy}, 64'd1);
    if (done) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("result",    {32'd0, result},      {32'd0, e.diff});
        checkOutput("carry_out", {63'd0, carry_out},   {63'd0, e.co});
        checkOutput("overflow",  {63'd0, overflow},    {63'd0, e.ov});
        checkOutput("latency",   64'(edgeCount),       64'(e.doneEdge));
        checkOutput("ready_in_done", {63'd0, ready},   64'd1);
      end
    end
  end

  // Issue one op at the current negedge (DUT must be ready), keep start noisy while busy,
  // and return at the negedge where ready rises again.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noisy);
    int n;
    start         = 1'b1;
    data_operandA = a;
    data_operandB = b;
    sbQueue.push_back(model(a, b, edgeCount + 17));
    n = 0;
    do begin
      @(negedge clock);
      n = n + 1;
      if (!ready) begin
        start         = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        data_operandA = noisy ? $urandom : a;
        data_operandB = noisy ? $urandom : b;
      end
    end while (!ready && n < 40);
    if (n >= 40) checkOutput("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleGap(input int cycles);
    start = 1'b0;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},  {63'd0, ready},     64'd1);
    checkOutput({tag, "_busy"},   {63'd0, busy},      64'd0);
    checkOutput({tag, "_done"},   {63'd0, done},      64'd0);
    checkOutput({tag, "_result"}, {32'd0, result},    64'd0);
    checkOutput({tag, "_co"},     {63'd0, carry_out}, 64'd0);
    checkOutput({tag, "_ov"},     {63'd0, overflow},  64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(32'd5, 32'd3, 1'b0);
    idleGap(2);
    applyStimulus(32'd3, 32'd5, 1'b0);
    idleGap(1);
    applyStimulus(32'h8000_0000, 32'd1, 1'b0);
    idleGap(1);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idleGap(1);

    // Zero difference with an ignored start (A=1, B=1) a few cycles into RUN.
    start = 1'b1; data_operandA = 32'hA5A5_A5A5; data_operandB = 32'hA5A5_A5A5;
    sbQueue.push_back(model(32'hA5A5_A5A5, 32'hA5A5_A5A5, edgeCount + 17));
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; data_operandA = 32'd1; data_operandB = 32'd1;
    @(negedge clock); start = 1'b0;
    repeat (40) begin
      if (ready) break;
      @(negedge clock);
    end
    idleGap(2);

    // Reset at RUN slice 7: partial result discarded, no done.
    start = 1'b1; data_operandA = 32'h1234_5678; data_operandB = 32'h0000_1111;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkResetState("midrun_reset");
    reset = 1'b0;
    idleGap(20);

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; data_operandA = 32'd9; data_operandB = 32'd2;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    checkResetState("reset_start");
    idleGap(20);

    // Back-to-back: second start lands in the DONE cycle of the first.
    applyStimulus(32'd10, 32'd4, 1'b0);
    applyStimulus(32'd0, 32'd1, 1'b0);
    idleGap(1);

    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      applyStimulus(a, b, 1'b1);
      if ($urandom_range(0, 2) == 0) idleGap($urandom_range(1, 3));
    end
    idleGap(3);

    checkOutput("scoreboard_drained", 64'(sbQueue.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
